// File: rtl/clk_gen_pkg.sv
// Shared definitions for the programmable clock generator: channel state
// encoding, default parameter values and the effective high-time rule.
package clk_gen_pkg;

    // Default channel count and field widths used by the top level.
    localparam int DEF_NCH   = 4;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 8;

    // Working width for high-time arithmetic; any DIV_W up to 32 fits.
    localparam int HE_W = 32;

    // Per-channel operating state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2,
        ERR    = 2'd3
    } chan_state_e;

    // Resolve the programmed high time against the period:
    // 0 means 50% duty (rounded down), anything that would swallow the
    // whole period is clipped so at least one low cycle remains.
    function automatic logic [HE_W-1:0] eff_high(
        input logic [HE_W-1:0] n,
        input logic [HE_W-1:0] h
    );
        logic [HE_W-1:0] r;
        if (h == '0) begin
            r = n >> 1;
        end else if (h >= n) begin
            r = n - HE_W'(1);
        end else begin
            r = h;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One divider channel: shadowed period/high-time, phase counter, registered
// divided clock, end-of-period tick and a wrapping completed-period counter.
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             stop,
    input  logic             sync,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] high,
    output logic             out_clk,
    output logic             tick,
    output logic [CNT_W-1:0] period_cnt,
    output logic             cfg_err
);

    localparam logic [DIV_W-1:0] PH_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chan_state_e      state_reg, state_next;
    logic [DIV_W-1:0] ph_reg, ph_next;
    logic [DIV_W-1:0] n_s_reg, n_s_next;
    logic [DIV_W-1:0] h_s_reg, h_s_next;
    logic             out_reg, out_next;
    logic             tick_reg, tick_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             load;
    logic [DIV_W-1:0] ph_inc;
    logic             at_wrap;
    logic             div_legal;
    logic [HE_W-1:0]  he_full;

    // Values derived from the current shadows; the high-time rule is
    // evaluated in the wide package width so no bits are discarded.
    assign ph_inc    = ph_reg + PH_ONE;
    assign at_wrap   = (ph_reg == (n_s_reg - PH_ONE));
    assign div_legal = (div >= DIV_MIN);
    assign he_full   = eff_high(HE_W'(n_s_reg), HE_W'(h_s_reg));

    // Next-state decision: disable beats sync, sync beats stop, stop beats counting.
    always_comb begin
        state_next = state_reg;
        ph_next    = ph_reg;
        n_s_next   = n_s_reg;
        h_s_next   = h_s_reg;
        out_next   = out_reg;
        tick_next  = 1'b0;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;

        if (!en) begin
            // Drop to idle; the period counter keeps its value.
            state_next = IDLE;
            ph_next    = '0;
            out_next   = 1'b0;
            err_next   = 1'b0;
        end else if ((state_reg == IDLE) || sync) begin
            // First enabled edge or a phase-alignment request.
            load = 1'b1;
        end else begin
            case (state_reg)
                RUN, FROZEN: begin
                    if (stop) begin
                        // Hold phase, output and counter exactly where they are.
                        state_next = FROZEN;
                    end else if (at_wrap) begin
                        tick_next = 1'b1;
                        cnt_next  = cnt_reg + CNT_ONE;
                        load      = 1'b1;
                    end else begin
                        state_next = RUN;
                        ph_next    = ph_inc;
                        out_next   = (HE_W'(ph_inc) < he_full);
                    end
                end
                default: begin
                    // ERR waits for a load point (sync or re-enable).
                end
            endcase
        end

        if (load) begin
            // Start a fresh period from the live configuration inputs.
            n_s_next = div;
            h_s_next = high;
            ph_next  = '0;
            if (div_legal) begin
                state_next = RUN;
                out_next   = 1'b1;
                err_next   = 1'b0;
            end else begin
                state_next = ERR;
                out_next   = 1'b0;
                err_next   = 1'b1;
            end
        end
    end

    // Channel register bank, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            ph_reg    <= '0;
            n_s_reg   <= '0;
            h_s_reg   <= '0;
            out_reg   <= 1'b0;
            tick_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ph_reg    <= ph_next;
            n_s_reg   <= n_s_next;
            h_s_reg   <= h_s_next;
            out_reg   <= out_next;
            tick_reg  <= tick_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign out_clk    = out_reg;
    assign tick       = tick_reg;
    assign period_cnt = cnt_reg;
    assign cfg_err    = err_reg;

endmodule

// File: rtl/clk_gen_prog.sv
// Programmable multi-channel clock divider: NCH independent channels sharing
// clk, reset_n and sync. Per-channel buses are packed channel 0 lowest.
module clk_gen_prog
    import clk_gen_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       stop,
    input  logic                 sync,
    input  logic [NCH*DIV_W-1:0] div,
    input  logic [NCH*DIV_W-1:0] high,
    output logic [NCH-1:0]       out_clk,
    output logic [NCH-1:0]       tick,
    output logic [NCH*CNT_W-1:0] period_cnt,
    output logic [NCH-1:0]       cfg_err
);

    // One divider per channel; the top only slices the packed buses.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            clk_gen_chan #(
                .DIV_W (DIV_W),
                .CNT_W (CNT_W)
            ) u_chan (
                .clk        (clk),
                .reset_n    (reset_n),
                .en         (en[gi]),
                .stop       (stop[gi]),
                .sync       (sync),
                .div        (div[gi*DIV_W +: DIV_W]),
                .high       (high[gi*DIV_W +: DIV_W]),
                .out_clk    (out_clk[gi]),
                .tick       (tick[gi]),
                .period_cnt (period_cnt[gi*CNT_W +: CNT_W]),
                .cfg_err    (cfg_err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_gen_prog.sv
// Self-checking bench for clk_gen_prog: directed waveform scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_clk_gen_prog;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;
    localparam int CNT_W = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       stop;
    logic                 sync;
    logic [NCH*DIV_W-1:0] div;
    logic [NCH*DIV_W-1:0] high;
    logic [NCH-1:0]       out_clk;
    logic [NCH-1:0]       tick;
    logic [NCH*CNT_W-1:0] period_cnt;
    logic [NCH-1:0]       cfg_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_gen_prog #(
        .NCH   (NCH),
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .stop       (stop),
        .sync       (sync),
        .div        (div),
        .high       (high),
        .out_clk    (out_clk),
        .tick       (tick),
        .period_cnt (period_cnt),
        .cfg_err    (cfg_err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ch(input string field, input int ch, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL ch%0d %s: got %0d expected %0d at %0t", ch, field, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is: enabled-or-not, error-or-not, position inside the
    // period, the period/high values in force, and the completed-period count.
    int m_on   [NCH];
    int m_err  [NCH];
    int m_ph   [NCH];
    int m_n    [NCH];
    int m_h    [NCH];
    int m_cnt  [NCH];
    int m_tick [NCH];

    function automatic int he_of(input int n, input int h);
        if (h == 0) return n / 2;
        if (h >= n) return n - 1;
        return h;
    endfunction

    function automatic int m_out(input int i);
        if (m_on[i] == 0 || m_err[i] != 0) return 0;
        return (m_ph[i] < he_of(m_n[i], m_h[i])) ? 1 : 0;
    endfunction

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_on[i] = 0; m_err[i] = 0; m_ph[i] = 0; m_n[i] = 0;
            m_h[i] = 0; m_cnt[i] = 0; m_tick[i] = 0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            for (int i = 0; i < NCH; i++) begin
                int  dv;
                int  hv;
                bit  do_load;
                dv = int'(div[i*DIV_W +: DIV_W]);
                hv = int'(high[i*DIV_W +: DIV_W]);
                do_load = 1'b0;
                m_tick[i] = 0;
                if (!reset_n) begin
                    m_on[i] = 0; m_err[i] = 0; m_ph[i] = 0; m_n[i] = 0;
                    m_h[i] = 0; m_cnt[i] = 0;
                end else if (!en[i]) begin
                    m_on[i] = 0; m_err[i] = 0; m_ph[i] = 0;
                end else begin
                    do_load = (m_on[i] == 0) || sync;
                    if (!do_load && m_err[i] == 0 && !stop[i]) begin
                        if (m_ph[i] == m_n[i] - 1) begin
                            m_tick[i] = 1;
                            m_cnt[i]  = (m_cnt[i] + 1) % (1 << CNT_W);
                            do_load   = 1'b1;
                        end else begin
                            m_ph[i] = m_ph[i] + 1;
                        end
                    end
                    if (do_load) begin
                        m_n[i]   = dv;
                        m_h[i]   = hv;
                        m_ph[i]  = 0;
                        m_on[i]  = 1;
                        m_err[i] = (dv < 2) ? 1 : 0;
                    end
                end
            end
        end
    end

    // Compare every channel against the model one time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++) begin
                check_ch("out_clk", i, int'(out_clk[i]), m_out(i));
                check_ch("tick", i, int'(tick[i]), m_tick[i]);
                check_ch("period_cnt", i, int'(period_cnt[i*CNT_W +: CNT_W]), m_cnt[i]);
                check_ch("cfg_err", i, int'(cfg_err[i]), (m_on[i] != 0 && m_err[i] != 0) ? 1 : 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int ch, input int dv, input int hv);
        div[ch*DIV_W +: DIV_W]  = DIV_W'(dv);
        high[ch*DIV_W +: DIV_W] = DIV_W'(hv);
    endtask

    function automatic int cnt_of(input int ch);
        return int'(period_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic check_all_zero(input string name);
        check({name, " out_clk"}, int'(out_clk), 0);
        check({name, " tick"}, int'(tick), 0);
        check({name, " period_cnt"}, int'(period_cnt), 0);
        check({name, " cfg_err"}, int'(cfg_err), 0);
    endtask

    // ---------------- directed then random stimulus ----------------
    initial begin
        logic [15:0] cap;
        logic [15:0] tcap;
        int t0;
        int t3;

        reset_n = 1'b0;
        en      = '0;
        stop    = '0;
        sync    = 1'b0;
        div     = '0;
        high    = '0;
        cyc();
        cyc();
        check_all_zero("reset");
        reset_n = 1'b1;
        cyc();

        // N=6, H=0: 3 high / 3 low, tick every 6th cycle.
        set_ch(0, 6, 0);
        en[0] = 1'b1;
        cap = '0; tcap = '0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            cap  = {cap[14:0], out_clk[0]};
            tcap = {tcap[14:0], tick[0]};
        end
        check("n6 out_clk pattern", int'(cap[11:0]), 12'b111000111000);
        check("n6 tick pattern", int'(tcap[11:0]), 12'b000000100000);
        for (int k = 0; k < 19; k++) cyc();
        check("n6 period_cnt after 30", cnt_of(0), 5);
        $display("scenario n6: out=%b tick=%b cnt=%0d", cap[11:0], tcap[11:0], cnt_of(0));

        // N=5, H=9 clipped to 4; H changed to 0 mid-period takes effect next period.
        set_ch(1, 5, 9);
        en[1] = 1'b1;
        cap = '0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            cap = {cap[14:0], out_clk[1]};
            if (k == 1) set_ch(1, 5, 0);
        end
        check("n5 high-time pattern", int'(cap[14:0]), 15'b111101100011000);
        $display("scenario n5: out=%b", cap[14:0]);

        // N=6 frozen for 7 edges at ph=2 stretches the waveform by 7 cycles.
        set_ch(2, 6, 0);
        en[2] = 1'b1;
        cap = '0; tcap = '0;
        for (int k = 0; k < 14; k++) begin
            cyc();
            cap  = {cap[14:0], out_clk[2]};
            tcap = {tcap[14:0], tick[2]};
            if (k == 2) stop[2] = 1'b1;
            if (k == 9) stop[2] = 1'b0;
        end
        check("stop out_clk pattern", int'(cap[13:0]), 14'b11111111110001);
        check("stop tick pattern", int'(tcap[13:0]), 14'b00000000000001);
        $display("scenario stop: out=%b tick=%b", cap[13:0], tcap[13:0]);

        // Sync aligns N=4 and N=6 channels; ticks follow 4 and 6 cycles later.
        set_ch(3, 4, 0);
        en[3] = 1'b1;
        cyc(); cyc(); cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("sync ch0 out_clk", int'(out_clk[0]), 1);
        check("sync ch3 out_clk", int'(out_clk[3]), 1);
        check("sync ticks", int'(tick), 0);
        t0 = -1; t3 = -1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (tick[0] && t0 < 0) t0 = k;
            if (tick[3] && t3 < 0) t3 = k;
        end
        check("sync ch3 first tick distance", t3, 4);
        check("sync ch0 first tick distance", t0, 6);
        $display("scenario sync: ch0 tick at +%0d ch3 tick at +%0d", t0, t3);

        // Reset mid-period (ch0 at ph=3): outputs clear without a clock edge.
        set_ch(2, 2, 0);
        reset_n = 1'b0;
        #1;
        check_all_zero("async reset");
        cyc();
        reset_n = 1'b1;
        cyc();
        check("restart ch0 out_clk", int'(out_clk[0]), 1);
        check("restart no tick", int'(tick), 0);
        check("restart ch0 period_cnt", cnt_of(0), 0);
        $display("scenario reset: out=%b tick=%b", out_clk, tick);

        // CNT_W=3: ch2 with N=2 wraps its counter after 8 periods.
        for (int k = 0; k < 14; k++) cyc();
        check("wrap ch2 period_cnt at 7", cnt_of(2), 7);
        cyc(); cyc();
        check("wrap ch2 period_cnt back to 0", cnt_of(2), 0);
        $display("scenario wrap: ch2 cnt=%0d", cnt_of(2));

        // N=1 loaded by sync -> error; legal N only takes effect at next load point.
        set_ch(1, 1, 0);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("n1 cfg_err", int'(cfg_err[1]), 1);
        check("n1 out_clk", int'(out_clk[1]), 0);
        set_ch(1, 4, 0);
        cyc(); cyc(); cyc();
        check("n1 err held until load", int'(cfg_err[1]), 1);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("n4 recovery cfg_err", int'(cfg_err[1]), 0);
        check("n4 recovery out_clk", int'(out_clk[1]), 1);
        $display("scenario err: cfg_err=%b out=%b", cfg_err, out_clk);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(7) == 0) en[i] = ~en[i];
                if ($urandom_range(5) == 0) stop[i] = ~stop[i];
                if ($urandom_range(3) == 0)
                    set_ch(i, int'($urandom_range(12, 2)), int'($urandom_range(15, 0)));
            end
            sync = ($urandom_range(24) == 0);
            if ($urandom_range(399) == 0) begin
                reset_n = 1'b0;
                #1;
                check_all_zero("random async reset");
            end else begin
                reset_n = 1'b1;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
